digital_clock_pro: RTL and testbench

DIGITAL_CLOCK_PRO -- requirements
Module: digital_clock_pro

---
 rtl/digital_clock_pro.sv | 134 +++++++++++++
 tb/tb_digital_clock_pro.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/digital_clock_pro.sv
// Binary hh:mm:ss timekeeper with a run-gated prescaler, validated load and alarm.
// The BCD display digits are combinational, in either 24-hour or 12-hour form.
module digital_clock_pro #(
    parameter int CLOCK_FREQ = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       mode_12h,
    input  logic       load,
    input  logic [4:0] load_hours,
    input  logic [5:0] load_minutes,
    input  logic [5:0] load_seconds,
    input  logic       alarm_en,
    input  logic [4:0] alarm_hours,
    input  logic [5:0] alarm_minutes,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic [3:0] hour_ones,
    output logic [3:0] hour_tens,
    output logic       pm,
    output logic       tick,
    output logic       alarm_hit,
    output logic       load_err
);
    localparam int PW = (CLOCK_FREQ > 2) ? $clog2(CLOCK_FREQ) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLOCK_FREQ - 1);

    logic [PW-1:0] r_presc;
    logic [5:0]    r_sec;
    logic [5:0]    r_min;
    logic [4:0]    r_hr;
    logic          r_tick;
    logic          r_alarm_hit;
    logic          r_load_err;

    logic          w_wrap;
    logic          w_load_ok;
    logic          w_alarm_match;
    logic [5:0]    w_sec_nx;
    logic [5:0]    w_min_nx;
    logic [4:0]    w_hr_nx;
    logic [4:0]    w_disp_hr;
    logic [7:0]    w_sec_bcd;
    logic [7:0]    w_min_bcd;
    logic [7:0]    w_hr_bcd;

    assign w_wrap    = run && (r_presc == PRESC_MAX);
    assign w_load_ok = (load_hours <= 5'd23) && (load_minutes <= 6'd59) && (load_seconds <= 6'd59);

    // Time one second from now, with seconds -> minutes -> hours carries.
    always_comb begin
        w_sec_nx = (r_sec == 6'd59) ? 6'd0 : r_sec + 6'd1;
        w_min_nx = r_min;
        w_hr_nx  = r_hr;
        if (r_sec == 6'd59) begin
            w_min_nx = (r_min == 6'd59) ? 6'd0 : r_min + 6'd1;
            if (r_min == 6'd59) begin
                w_hr_nx = (r_hr == 5'd23) ? 5'd0 : r_hr + 5'd1;
            end
        end
    end

    // Out-of-range alarm settings can never equal an in-range time, so they never match.
    assign w_alarm_match = alarm_en && (w_hr_nx == alarm_hours) &&
                           (w_min_nx == alarm_minutes) && (w_sec_nx == 6'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc     <= '0;
            r_sec       <= 6'd0;
            r_min       <= 6'd0;
            r_hr        <= 5'd0;
            r_tick      <= 1'b0;
            r_alarm_hit <= 1'b0;
            r_load_err  <= 1'b0;
        end else if (load && w_load_ok) begin
            // A pending wrap in this cycle is discarded along with its tick and alarm.
            r_presc     <= '0;
            r_sec       <= load_seconds;
            r_min       <= load_minutes;
            r_hr        <= load_hours;
            r_tick      <= 1'b0;
            r_alarm_hit <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_load_err  <= load;
            r_tick      <= w_wrap;
            r_alarm_hit <= w_wrap && w_alarm_match;
            if (run) begin
                r_presc <= w_wrap ? '0 : r_presc + 1'b1;
            end
            if (w_wrap) begin
                r_sec <= w_sec_nx;
                r_min <= w_min_nx;
                r_hr  <= w_hr_nx;
            end
        end
    end

    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [5:0] t;
        t = v / 6'd10;
        return {t[3:0], 4'(v - t * 6'd10)};
    endfunction

    always_comb begin
        w_disp_hr = r_hr;
        if (mode_12h) begin
            if (r_hr == 5'd0) begin
                w_disp_hr = 5'd12;
            end else if (r_hr > 5'd12) begin
                w_disp_hr = r_hr - 5'd12;
            end
        end
    end

    assign w_sec_bcd = to_bcd(r_sec);
    assign w_min_bcd = to_bcd(r_min);
    assign w_hr_bcd  = to_bcd({1'b0, w_disp_hr});

    assign sec_ones  = w_sec_bcd[3:0];
    assign sec_tens  = w_sec_bcd[7:4];
    assign min_ones  = w_min_bcd[3:0];
    assign min_tens  = w_min_bcd[7:4];
    assign hour_ones = w_hr_bcd[3:0];
    assign hour_tens = w_hr_bcd[7:4];
    assign pm        = (r_hr >= 5'd12);
    assign tick      = r_tick;
    assign alarm_hit = r_alarm_hit;
    assign load_err  = r_load_err;
endmodule

// File: tb/tb_digital_clock_pro.sv
// Bench for digital_clock_pro at CLOCK_FREQ=4: expected pulse events are queued by the
// stimulus and checked by a negedge monitor; static display values are checked directly.
module tb_digital_clock_pro;
    localparam logic [2:0] EV_TICK = 3'b100;
    localparam logic [2:0] EV_ALM  = 3'b010;
    localparam logic [2:0] EV_ERR  = 3'b001;

    typedef struct packed {
        logic [2:0]  ev;
        logic [23:0] dig;
        logic        pm;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset, run, mode_12h, load, alarm_en;
    logic [4:0] load_hours, alarm_hours;
    logic [5:0] load_minutes, load_seconds, alarm_minutes;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens, hour_ones, hour_tens;
    logic       pm, tick, alarm_hit, load_err;
    logic [23:0] w_dig;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic [2:0] prev_ev = 3'b000;

    digital_clock_pro #(.CLOCK_FREQ(4)) dut (
        .clk(clk), .reset(reset), .run(run), .mode_12h(mode_12h), .load(load),
        .load_hours(load_hours), .load_minutes(load_minutes), .load_seconds(load_seconds),
        .alarm_en(alarm_en), .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes),
        .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones), .min_tens(min_tens),
        .hour_ones(hour_ones), .hour_tens(hour_tens), .pm(pm), .tick(tick),
        .alarm_hit(alarm_hit), .load_err(load_err)
    );

    always #5 clk = ~clk;

    assign w_dig = {hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones};

    // Monitor: every pulse the DUT presents consumes one queued expectation.
    always @(negedge clk) begin
        logic [2:0] cur_ev;
        exp_t e;
        cur_ev = {tick, alarm_hit, load_err};
        if (cur_ev != 3'b000) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_pulse: got ev=%b dig=%h pm=%b, required no pulse", cur_ev, w_dig, pm);
            end else begin
                e = sb.pop_front();
                if ({cur_ev, w_dig, pm} != {e.ev, e.dig, e.pm}) begin
                    n_err++;
                    $display("FAIL pulse_event: got ev=%b dig=%h pm=%b, required ev=%b dig=%h pm=%b",
                             cur_ev, w_dig, pm, e.ev, e.dig, e.pm);
                end else begin
                    $display("event ev=%b dig=%h pm=%b ok", cur_ev, w_dig, pm);
                end
            end
            if ((cur_ev & prev_ev) != 3'b000) begin
                n_err++;
                $display("FAIL pulse_width: got ev=%b on consecutive cycles, required single-cycle", cur_ev & prev_ev);
            end
        end
        prev_ev = cur_ev;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] ev, input logic [23:0] dig, input logic p);
        exp_t e;
        e.ev = ev; e.dig = dig; e.pm = p;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end else begin
            $display("check %s = %h ok", name, act);
        end
    endtask

    task automatic do_load(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        load_hours = h; load_minutes = m; load_seconds = s;
        load = 1'b1;
        step(1);
        load = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; run = 1'b0; mode_12h = 1'b0; load = 1'b0; alarm_en = 1'b0;
        load_hours = '0; load_minutes = '0; load_seconds = '0;
        alarm_hours = '0; alarm_minutes = '0;
        step(2);
        reset = 1'b0;
        chk("rst_dig_24h", {8'h0, w_dig}, 32'h0);
        chk("rst_pulses", {29'h0, tick, alarm_hit, load_err}, 32'h0);
        mode_12h = 1'b1; #1;
        chk("rst_dig_12h", {7'h0, w_dig, pm}, {7'h0, 24'h120000, 1'b0});
        mode_12h = 1'b0;

        // Three ticks in 12 running cycles.
        push(EV_TICK, 24'h000001, 1'b0);
        push(EV_TICK, 24'h000002, 1'b0);
        push(EV_TICK, 24'h000003, 1'b0);
        run = 1'b1;
        step(3);
        chk("no_tick_cyc3", {31'h0, tick}, 32'h0);
        step(1);
        chk("tick_cyc4", {31'h0, tick}, 32'h1);
        step(8);
        chk("tick_cyc12", {31'h0, tick}, 32'h1);
        run = 1'b0;
        chk("time_3s", {8'h0, w_dig}, 32'h000003);

        // Pause mid-count: the remaining two counts follow the resume.
        run = 1'b1; step(2);
        run = 1'b0; step(10);
        chk("paused_time", {8'h0, w_dig}, 32'h000003);
        push(EV_TICK, 24'h000004, 1'b0);
        run = 1'b1; step(1);
        chk("resume_no_tick", {31'h0, tick}, 32'h0);
        step(1);
        chk("resume_tick", {31'h0, tick}, 32'h1);
        run = 1'b0;

        // Midnight rollover.
        do_load(5'd23, 6'd59, 6'd59);
        chk("load_2359", {7'h0, w_dig, pm}, {7'h0, 24'h235959, 1'b1});
        push(EV_TICK, 24'h000000, 1'b0);
        run = 1'b1; step(4); run = 1'b0;
        chk("midnight_24h", {7'h0, w_dig, pm}, {7'h0, 24'h000000, 1'b0});
        mode_12h = 1'b1; #1;
        chk("midnight_12h", {7'h0, w_dig, pm}, {7'h0, 24'h120000, 1'b0});
        mode_12h = 1'b0;

        // 12/24-hour display switch takes effect combinationally.
        do_load(5'd13, 6'd5, 6'd0);
        mode_12h = 1'b1; #1;
        chk("pm_12h", {7'h0, w_dig, pm}, {7'h0, 24'h010500, 1'b1});
        mode_12h = 1'b0; #1;
        chk("pm_24h", {7'h0, w_dig, pm}, {7'h0, 24'h130500, 1'b1});

        // Rejected loads keep the time and the prescaler phase.
        run = 1'b1; step(2);
        push(EV_ERR, 24'h130500, 1'b1);
        do_load(5'd24, 6'd0, 6'd0);
        push(EV_TICK, 24'h130501, 1'b1);
        step(1);
        chk("phase_after_bad_hr", {31'h0, tick}, 32'h1);
        push(EV_ERR, 24'h130501, 1'b1);
        do_load(5'd10, 6'd60, 6'd0);
        push(EV_TICK, 24'h130502, 1'b1);
        step(2);
        chk("bad_min_no_tick", {31'h0, tick}, 32'h0);
        step(1);
        chk("phase_after_bad_min", {31'h0, tick}, 32'h1);
        run = 1'b0;

        // Alarm fires on a wrap into 07:30:00, not on a load of it, and not when disabled.
        alarm_hours = 5'd7; alarm_minutes = 6'd30; alarm_en = 1'b1;
        do_load(5'd7, 6'd29, 6'd59);
        push(EV_TICK | EV_ALM, 24'h073000, 1'b0);
        run = 1'b1; step(4); run = 1'b0;
        do_load(5'd7, 6'd30, 6'd0);
        chk("load_no_alarm", {31'h0, alarm_hit}, 32'h0);
        step(1);
        chk("load_no_alarm2", {31'h0, alarm_hit}, 32'h0);
        alarm_en = 1'b0;
        do_load(5'd7, 6'd29, 6'd59);
        push(EV_TICK, 24'h073000, 1'b0);
        run = 1'b1; step(4); run = 1'b0;

        // Reset beats a simultaneous valid load.
        load_hours = 5'd12; load_minutes = 6'd0; load_seconds = 6'd0;
        load = 1'b1; reset = 1'b1;
        step(1);
        load = 1'b0; reset = 1'b0;
        chk("reset_over_load", {7'h0, w_dig, pm}, {7'h0, 24'h000000, 1'b0});
        step(3);

        chk("sb_drained", sb.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
